// File: rtl/game_round_controller.sv
// game_round_controller: round sequencer for the binary counting game (LFSR target, round timer, score).
// Latency: a button press acts on the first clock edge that samples it high; every output is registered.
// Backpressure: none; buttons are edge-detected, and edges the current state does not use are dropped.
// Option GAME_RETRY_EN: a wrong submit only pulses result_bad for one cycle and the round keeps running.
module game_round_controller #(
  parameter int TICK_DIV        = 1000,
  parameter int ROUND_TICKS     = 30,
  parameter int ROUNDS          = 8,
  parameter int FEEDBACK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       submit,
  input  logic [7:0] guess,
  output logic [7:0] target,
  output logic [3:0] score,
  output logic [3:0] round,
  output logic [7:0] time_left,
  output logic [1:0] state,
  output logic       result_ok,
  output logic       result_bad
);

  // Prescaler holds 0..TICK_DIV-1; feedback counter holds 0..FEEDBACK_CYCLES-1.
  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FB_W = (FEEDBACK_CYCLES > 1) ? $clog2(FEEDBACK_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PLAY     = 2'b01,
    ST_FEEDBACK = 2'b10,
    ST_DONE     = 2'b11
  } state_e;

  state_e          state_q, state_nxt;
  logic [7:0]      lfsr_q;
  logic            start_q, submit_q;
  logic            start_edge, submit_edge;
  logic [PS_W-1:0] presc_q, presc_d;
  logic [FB_W-1:0] fb_cnt_q, fb_cnt_d;
  logic [7:0]      target_q, target_d;
  logic [7:0]      time_left_q, time_left_d;
  logic [3:0]      score_q, score_d;
  logic [3:0]      round_q, round_d;
  logic            ok_q, ok_d;
  logic            bad_q, bad_d;
  logic            tick_wrap, timeout, guess_hit, guess_miss, miss_ends;
  logic            fb_done, last_round;

  assign start_edge  = start & ~start_q;
  assign submit_edge = submit & ~submit_q;

  assign tick_wrap   = (presc_q == PS_W'(TICK_DIV - 1));
  assign timeout     = tick_wrap && (time_left_q == 8'd1);
  assign guess_hit   = submit_edge && (guess == target_q);
  assign guess_miss  = submit_edge && (guess != target_q);
  assign fb_done     = (fb_cnt_q == FB_W'(FEEDBACK_CYCLES - 1));
  assign last_round  = (round_q == 4'(ROUNDS));

`ifdef GAME_RETRY_EN
  // A wrong answer is only flagged; the player may try again until the timer runs out.
  assign miss_ends = 1'b0;
`else
  assign miss_ends = guess_miss;
`endif

  // Free-running Fibonacci LFSR and button edge registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q   <= 8'hA5;
      start_q  <= 1'b0;
      submit_q <= 1'b0;
    end else begin
      lfsr_q   <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      start_q  <= start;
      submit_q <= submit;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state decision; a submit result takes priority over a same-cycle timeout.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge) state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (guess_hit || miss_ends || timeout) state_nxt = ST_FEEDBACK;
      end
      ST_FEEDBACK: begin
        if (fb_done) state_nxt = last_round ? ST_DONE : ST_PLAY;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the round datapath and result flags.
  always_comb begin
    presc_d     = presc_q;
    fb_cnt_d    = fb_cnt_q;
    target_d    = target_q;
    time_left_d = time_left_q;
    score_d     = score_q;
    round_d     = round_q;
    ok_d        = ok_q;
    bad_d       = bad_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          score_d     = 4'd0;
          round_d     = 4'd1;
          target_d    = lfsr_q;
          time_left_d = 8'(ROUND_TICKS);
          presc_d     = '0;
          fb_cnt_d    = '0;
          ok_d        = 1'b0;
          bad_d       = 1'b0;
        end
      end
      ST_PLAY: begin
        ok_d     = 1'b0;
        bad_d    = 1'b0;
        fb_cnt_d = '0;
        if (tick_wrap) begin
          presc_d     = '0;
          time_left_d = time_left_q - 8'd1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
        if (guess_hit) begin
          ok_d    = 1'b1;
          score_d = (score_q == 4'hF) ? score_q : score_q + 4'd1;
        end else if (guess_miss || timeout) begin
          bad_d = 1'b1;
        end
      end
      ST_FEEDBACK: begin
        if (fb_done) begin
          fb_cnt_d = '0;
          if (!last_round) begin
            round_d     = round_q + 4'd1;
            target_d    = lfsr_q;
            time_left_d = 8'(ROUND_TICKS);
            presc_d     = '0;
            ok_d        = 1'b0;
            bad_d       = 1'b0;
          end
        end else begin
          fb_cnt_d = fb_cnt_q + 1'b1;
        end
      end
      default: begin
        ok_d  = 1'b0;
        bad_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      fb_cnt_q    <= '0;
      target_q    <= 8'd0;
      time_left_q <= 8'd0;
      score_q     <= 4'd0;
      round_q     <= 4'd0;
      ok_q        <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      fb_cnt_q    <= fb_cnt_d;
      target_q    <= target_d;
      time_left_q <= time_left_d;
      score_q     <= score_d;
      round_q     <= round_d;
      ok_q        <= ok_d;
      bad_q       <= bad_d;
    end
  end

  assign target     = target_q;
  assign score      = score_q;
  assign round      = round_q;
  assign time_left  = time_left_q;
  assign state      = state_q;
  assign result_ok  = ok_q;
  assign result_bad = bad_q;

endmodule

// File: tb/tb_game_round_controller.sv
// tb_game_round_controller: directed checks of the round sequencer with a short round/feedback setup.
// Latency: inputs change on the falling edge, outputs are sampled 1 time unit after the rising edge.
// Backpressure: none; fixed cycle counts only, so the run always terminates.
module tb_game_round_controller;

  localparam int TD = 2;
  localparam int RT = 4;
  localparam int NR = 2;
  localparam int FC = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       submit = 1'b0;
  logic [7:0] guess = 8'd0;
  logic [7:0] target;
  logic [3:0] score;
  logic [3:0] round;
  logic [7:0] time_left;
  logic [1:0] state;
  logic       result_ok;
  logic       result_bad;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] m_lfsr;
  logic [7:0] snap;
  logic [7:0] exp_target;
  int         exp_score;

  game_round_controller #(
    .TICK_DIV(TD), .ROUND_TICKS(RT), .ROUNDS(NR), .FEEDBACK_CYCLES(FC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .submit(submit), .guess(guess),
    .target(target), .score(score), .round(round), .time_left(time_left),
    .state(state), .result_ok(result_ok), .result_bad(result_bad)
  );

  always #5 clk = ~clk;

  // Reference LFSR, seeded and stepped the way the game describes it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Raise start for one cycle; snap holds the LFSR value the DUT sees on that edge.
  task automatic press_start();
    @(negedge clk);
    start = 1'b1;
    snap  = m_lfsr;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic press_submit(input logic [7:0] value);
    @(negedge clk);
    guess  = value;
    submit = 1'b1;
    @(posedge clk);
    #1;
    submit = 1'b0;
  endtask

  // Sit out the feedback window; snap catches the LFSR on the edge that leaves it.
  task automatic ride_feedback();
    repeat (FC - 1) @(posedge clk);
    #1;
    check("fb_hold_state", state, 2'b10);
    @(negedge clk);
    snap = m_lfsr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state, 2'b00);
    check("rst_target", target, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_state", state, 2'b00);
    check("idle_target", target, 8'd0);
    check("idle_score", score, 4'd0);
    check("idle_round", round, 4'd0);
    check("idle_time", time_left, 8'd0);
    check("idle_flags", {result_ok, result_bad}, 2'b00);

    // Game 1, round 1: correct answer
    press_start();
    exp_target = snap;
    exp_score  = 0;
    check("g1r1_state", state, 2'b01);
    check("g1r1_round", round, 4'd1);
    check("g1r1_time", time_left, 8'd4);
    check("g1r1_target", target, exp_target);
    press_submit(exp_target);
    exp_score = 1;
    check("hit_state", state, 2'b10);
    check("hit_flags", {result_ok, result_bad}, 2'b10);
    check("hit_score", score, exp_score);
    ride_feedback();
    exp_target = snap;
    check("g1r2_state", state, 2'b01);
    check("g1r2_round", round, 4'd2);
    check("g1r2_time", time_left, 8'd4);
    check("g1r2_flags", {result_ok, result_bad}, 2'b00);
    check("g1r2_target", target, exp_target);

    // Game 1, round 2: wrong answer
    press_submit(exp_target ^ 8'h01);
`ifdef GAME_RETRY_EN
    check("retry_state", state, 2'b01);
    check("retry_flags", {result_ok, result_bad}, 2'b01);
    @(posedge clk);
    #1;
    check("retry_pulse_end", {result_ok, result_bad}, 2'b00);
    check("retry_still_play", state, 2'b01);
    press_submit(exp_target);
    exp_score = 2;
    check("retry_hit_state", state, 2'b10);
    check("retry_hit_flags", {result_ok, result_bad}, 2'b10);
`else
    check("miss_state", state, 2'b10);
    check("miss_flags", {result_ok, result_bad}, 2'b01);
`endif
    check("miss_score", score, exp_score);
    ride_feedback();
    check("done_state", state, 2'b11);
    check("done_score", score, exp_score);
    check("done_round", round, 4'd2);
    press_submit(exp_target);
    check("done_ign_state", state, 2'b11);
    check("done_ign_score", score, exp_score);

    // Game 2, round 1: timeout
    press_start();
    exp_target = snap;
    check("g2_state", state, 2'b01);
    check("g2_round", round, 4'd1);
    check("g2_score", score, 4'd0);
    check("g2_flags", {result_ok, result_bad}, 2'b00);
    check("g2_target", target, exp_target);
    for (int k = 1; k <= RT; k++) begin
      @(posedge clk);
      #1;
      check("to_mid_state", state, 2'b01);
      @(posedge clk);
      #1;
      check("to_time", time_left, 32'(RT - k));
      check("to_state", state, (k == RT) ? 2'b10 : 2'b01);
    end
    check("to_flags", {result_ok, result_bad}, 2'b01);
    check("to_score", score, 4'd0);
    ride_feedback();
    exp_target = snap;
    check("g2r2_state", state, 2'b01);
    check("g2r2_target", target, exp_target);

    // Game 2, round 2: correct submit on the final tick-wrap edge
    repeat (RT * TD - 1) @(posedge clk);
    #1;
    check("edge_pre_time", time_left, 8'd1);
    check("edge_pre_state", state, 2'b01);
    press_submit(exp_target);
    check("edge_state", state, 2'b10);
    check("edge_flags", {result_ok, result_bad}, 2'b10);
    check("edge_score", score, 4'd1);
    ride_feedback();
    check("g2_done", state, 2'b11);

    // Reset in the middle of a round
    press_start();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", state, 2'b00);
    check("mid_rst_target", target, 8'd0);
    check("mid_rst_round", round, 4'd0);
    check("mid_rst_time", time_left, 8'd0);
    check("mid_rst_score", score, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_idle", state, 2'b00);
    press_start();
    check("post_rst_play", state, 2'b01);
    check("post_rst_target", target, snap);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
